mem_requester: RTL

- Initiator-side adapter that drives the word-addressed single-cycle-read data memory (registered read port, independent write port) from a valid/ready load/store request channel.
- Converts byte addresses to word indices and performs read-modify-write for partial-byte stores.
- Returns one response per request on a valid/ready response channel.
- Sits between the core's load/store stage and the data memory instance.

---
 rtl/mem_requester.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_requester.sv
// Load/store adapter between a valid/ready request channel and a word-addressed
// memory with a registered read port; partial stores are done as read-modify-write.
module mem_requester #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [WIDTH-1:0]         req_wdata_i,
  input  logic [WIDTH/8-1:0]       req_be_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     mem_read_en_o,
  output logic [$clog2(DEPTH)-1:0] mem_read_pos_o,
  input  logic [WIDTH-1:0]         mem_read_data_i,
  output logic                     mem_write_en_o,
  output logic [$clog2(DEPTH)-1:0] mem_write_pos_o,
  output logic [WIDTH-1:0]         mem_write_data_o,
  output logic [2:0]               dbg_state_o
);

  localparam int BYTES = WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [IDXW-1:0]   r_idx;
  logic [BYTES-1:0]  r_be;
  logic [WIDTH-1:0]  r_wr_data;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_err;
  logic              w_be_none;
  logic              w_be_full;
  logic [WIDTH-1:0]  w_merge;

  // Handshakes: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; a response transfers where rsp_valid_o and
  // rsp_ready_i are both high. Neither valid may depend on its ready.
  assign w_accept       = req_valid_i && (r_state == S_IDLE);
  assign w_misaligned   = |(req_addr_i & OFF_MASK);
  assign w_out_of_range = (req_addr_i >> OFF) >= DEPTH_A;
  assign w_err          = w_misaligned || w_out_of_range;
  assign w_be_none      = (req_be_i == '0);
  assign w_be_full      = &req_be_i;

  // Bytes not enabled keep the value just read back from memory.
  always_comb begin
    w_merge = r_wr_data;
    for (int i = 0; i < BYTES; i++) begin
      if (!r_be[i]) w_merge[8*i +: 8] = mem_read_data_i[8*i +: 8];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)                      w_next = S_RESP;
          else if (req_we_i && w_be_none) w_next = S_RESP;
          else if (req_we_i && w_be_full) w_next = S_WRITE;
          else                            w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  if (rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_idx     <= '0;
      r_be      <= '0;
      r_wr_data <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we      <= req_we_i;
        r_idx     <= req_addr_i[OFF +: IDXW];
        r_be      <= req_be_i;
        r_wr_data <= req_wdata_i;
        r_rdata   <= '0;
        r_err     <= w_err;
      end else if (r_state == S_WAIT) begin
        if (r_we) r_wr_data <= w_merge;
        else      r_rdata   <= mem_read_data_i;
      end
    end
  end

  assign req_ready_o      = (r_state == S_IDLE);
  assign rsp_valid_o      = (r_state == S_RESP);
  assign rsp_rdata_o      = r_rdata;
  assign rsp_err_o        = r_err;
  assign mem_read_en_o    = (r_state == S_READ);
  assign mem_read_pos_o   = r_idx;
  assign mem_write_en_o   = (r_state == S_WRITE);
  assign mem_write_pos_o  = r_idx;
  assign mem_write_data_o = r_wr_data;
  assign dbg_state_o      = r_state;

endmodule
